julia_iter_ctrl: RTL and testbench
==================================

# julia_iter_ctrl

Iteration sequencer for the Julia-set complex datapath (z := z² + c, IEEE-754 single precision). It latches a starting point z0 and a constant c, then repeatedly drives the datapath inputs and waits out the fixed pipeline latency. Each result is fed back as the next z until the point escapes or an iteration cap is hit. It sits between the pixel/point generator and the datapath instance, and returns an iteration count per point for colouring.

## Interface
- PIPE_LAT, 19, datapath latency in cycles from input change to valid rfinal/ifinal (mult 5 + add 7 + add 7); must be >= 2
- MAX_ITER, 255, iteration cap; must be >= 1 and < 2^ITER_W
- ITER_W, 8, width of iteration counter
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request; accepted only in IDLE
- z0_re, z0_im  in  32  starting z, IEEE single
- c_re, c_im  in  32  constant c, IEEE single
- busy  out  1  high from start acceptance until done cycle inclusive
- done  out  1  one-cycle pulse, result valid
- iter_count  out  ITER_W  completed iterations for the last point
- escaped  out  1  1 = escaped, 0 = hit MAX_ITER
- z_re_out, z_im_out  out  32  last sampled z
- dp_aclr  out  1  datapath clear
- dp_rz, dp_iz, dp_rc, dp_ic  out  32  datapath inputs (registered)
- dp_rfinal, dp_ifinal  in  32  datapath results
- dp_overflow  in  1  datapath multiplier overflow

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: busy=0, dp_aclr=1.
  - On start: latch z0 into dp_rz/dp_iz and c into dp_rc/dp_ic. Clear iter to 0 and escaped to 0. Go to ISSUE.
- ISSUE (1 cycle): dp_aclr=0. Load wait counter with PIPE_LAT-2. Go to WAIT.
- WAIT: count down.
  - At the edge ending the cycle with counter 0, sample dp_rfinal/dp_ifinal into dp_rz/dp_iz and into z_re_out/z_im_out. Set iter := iter+1.
  - Escape test on the sampled values: escape = (rfinal[30:23] >= 8'd128) OR (ifinal[30:23] >= 8'd128) OR dp_overflow. This is a box test |re| >= 2 or |im| >= 2, and it covers Inf/NaN.
  - If escape: escaped := 1, go to DONE. Else if iter+1 == MAX_ITER: go to DONE. Else go to ISSUE.
- Escape has priority over the cap: an escape on iteration MAX_ITER reports escaped=1, iter_count=MAX_ITER.
- z0 itself is never escape-tested; at least one iteration always runs.
- DONE (1 cycle): done=1, busy=1, dp_aclr=1. Go to IDLE.
- iter_count, escaped and z_*_out hold their values until the next accepted start.
- start while not in IDLE (including during DONE) is ignored, with no queueing.
- dp_rc/dp_ic stay constant for the whole point.

## Timing
- Reset values: busy=0, done=0, iter_count=0, escaped=0, z_re_out=z_im_out=0, dp_rz=dp_iz=dp_rc=dp_ic=0, dp_aclr=1, state=IDLE.
- start sampled at edge E: dp inputs valid from E, and busy is high in the cycle after E.
- Iteration k result is sampled at edge E + k·PIPE_LAT. New dp_rz/dp_iz are presented from that same edge, so the iteration period is exactly PIPE_LAT cycles.
- For N iterations, done is high in the cycle following edge E + N·PIPE_LAT. Next start is accepted at the edge ending the first IDLE cycle, i.e. E + N·PIPE_LAT + 2 at the earliest.
- rst high at any edge forces reset values on that edge, including mid-iteration. In-flight datapath results are discarded, and dp_aclr=1 from the next cycle.

## Test plan
- Reset: hold rst 3 cycles with start=1 -> all outputs at reset values, busy stays 0, start ignored.
- z0=0x00000000, c=0x40000000 (2.0), start at edge E -> done in the cycle after E+19, iter_count=1, escaped=1, z_re_out=0x40000000.
- z0=0, c=0x3F800000 (1.0) -> z=1.0 then 2.0; done after E+38, iter_count=2, escaped=1.
- z0=0, c=0xBF800000 (-1.0) -> z alternates -1/0, never escapes; done after E+255·19=E+4845, iter_count=255, escaped=0. busy is high throughout, and a start pulse mid-run is ignored.
- Force dp_overflow=1 during the first sample with c=0 -> iter_count=1, escaped=1.
- Start with c=-1.0, assert rst at E+100 for 1 cycle -> outputs return to reset values, no done pulse. A new start with c=2.0 then completes normally with iter_count=1.

Source files
------------

// File: rtl/julia_iter_ctrl.sv
// julia_iter_ctrl: sequences z := z^2 + c through a fixed-latency datapath and
// reports the iteration count and escape status for each point.
`default_nettype none

module julia_iter_ctrl #(
  parameter int PIPE_LAT = 19,
  parameter int MAX_ITER = 255,
  parameter int ITER_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [31:0]       z0_re,
  input  logic [31:0]       z0_im,
  input  logic [31:0]       c_re,
  input  logic [31:0]       c_im,
  output logic              busy,
  output logic              done,
  output logic [ITER_W-1:0] iter_count,
  output logic              escaped,
  output logic [31:0]       z_re_out,
  output logic [31:0]       z_im_out,
  output logic              dp_aclr,
  output logic [31:0]       dp_rz,
  output logic [31:0]       dp_iz,
  output logic [31:0]       dp_rc,
  output logic [31:0]       dp_ic,
  input  logic [31:0]       dp_rfinal,
  input  logic [31:0]       dp_ifinal,
  input  logic              dp_overflow
);

  localparam int CNT_W = (PIPE_LAT > 2) ? $clog2(PIPE_LAT - 1) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       state;
  logic [CNT_W-1:0] wait_cnt;
  logic [ITER_W:0]  iter_next;
  logic             cap_hit;
  logic             escape;

  // Box test |re| >= 2 or |im| >= 2; biased exponent >= 128 also catches Inf/NaN.
  assign escape    = (dp_rfinal[30:23] >= 8'd128) || (dp_ifinal[30:23] >= 8'd128) || dp_overflow;
  assign iter_next = {1'b0, iter_count} + 1'b1;
  assign cap_hit   = (iter_next == (ITER_W+1)'(MAX_ITER));

  assign busy    = (state != S_IDLE);
  assign done    = (state == S_DONE);
  assign dp_aclr = (state == S_IDLE) || (state == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      wait_cnt   <= '0;
      iter_count <= '0;
      escaped    <= 1'b0;
      z_re_out   <= '0;
      z_im_out   <= '0;
      dp_rz      <= '0;
      dp_iz      <= '0;
      dp_rc      <= '0;
      dp_ic      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            dp_rz      <= z0_re;
            dp_iz      <= z0_im;
            dp_rc      <= c_re;
            dp_ic      <= c_im;
            iter_count <= '0;
            escaped    <= 1'b0;
            state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          wait_cnt <= CNT_W'(PIPE_LAT - 2);
          state    <= S_WAIT;
        end
        S_WAIT: begin
          if (wait_cnt == '0) begin
            // Result becomes the next z immediately, keeping the period at PIPE_LAT.
            dp_rz      <= dp_rfinal;
            dp_iz      <= dp_ifinal;
            z_re_out   <= dp_rfinal;
            z_im_out   <= dp_ifinal;
            iter_count <= iter_next[ITER_W-1:0];
            if (escape) begin
              escaped <= 1'b1;
              state   <= S_DONE;
            end else if (cap_hit) begin
              state <= S_DONE;
            end else begin
              state <= S_ISSUE;
            end
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_julia_iter_ctrl.sv
// tb_julia_iter_ctrl: directed checks of julia_iter_ctrl against a behavioural
// z^2 + c datapath with the same fixed latency.
`default_nettype none

module tb_julia_iter_ctrl;

  localparam int PIPE_LAT = 19;
  localparam int MAX_ITER = 255;
  localparam int ITER_W   = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [31:0]       z0_re, z0_im, c_re, c_im;
  logic              busy, done, escaped, dp_aclr;
  logic [ITER_W-1:0] iter_count;
  logic [31:0]       z_re_out, z_im_out;
  logic [31:0]       dp_rz, dp_iz, dp_rc, dp_ic;
  logic [31:0]       dp_rfinal, dp_ifinal;
  logic              dp_overflow;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  julia_iter_ctrl #(.PIPE_LAT(PIPE_LAT), .MAX_ITER(MAX_ITER), .ITER_W(ITER_W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .z0_re(z0_re), .z0_im(z0_im), .c_re(c_re), .c_im(c_im),
    .busy(busy), .done(done), .iter_count(iter_count), .escaped(escaped),
    .z_re_out(z_re_out), .z_im_out(z_im_out), .dp_aclr(dp_aclr),
    .dp_rz(dp_rz), .dp_iz(dp_iz), .dp_rc(dp_rc), .dp_ic(dp_ic),
    .dp_rfinal(dp_rfinal), .dp_ifinal(dp_ifinal), .dp_overflow(dp_overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic real sp2real(logic [31:0] b);
    logic [63:0] d;
    if (b[30:23] == 8'd0) return 0.0;
    d = {b[31], 11'(int'(b[30:23]) - 127 + 1023), b[22:0], 29'b0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] real2sp(real r);
    logic [63:0] d;
    int e;
    d = $realtobits(r);
    e = int'(d[62:52]) - 1023 + 127;
    if (r == 0.0 || e <= 0) return 32'h0;
    if (e >= 255) return {d[63], 8'hFF, 23'h0};
    return {d[63], e[7:0], d[51:29]};
  endfunction

  // Behavioural datapath: result of inputs present at edge k is visible just
  // before edge k + PIPE_LAT - 1, i.e. sampled by the DUT PIPE_LAT edges after change.
  logic [31:0] pipe_re [PIPE_LAT-1];
  logic [31:0] pipe_im [PIPE_LAT-1];
  always @(posedge clk) begin
    real zr, zi, cr, ci;
    zr = sp2real(dp_rz); zi = sp2real(dp_iz);
    cr = sp2real(dp_rc); ci = sp2real(dp_ic);
    pipe_re[0] <= real2sp(zr * zr - zi * zi + cr);
    pipe_im[0] <= real2sp(2.0 * zr * zi + ci);
    for (int i = 1; i < PIPE_LAT - 1; i++) begin
      pipe_re[i] <= pipe_re[i-1];
      pipe_im[i] <= pipe_im[i-1];
    end
  end
  assign dp_rfinal = pipe_re[PIPE_LAT-2];
  assign dp_ifinal = pipe_im[PIPE_LAT-2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " busy"}, 64'(busy), 64'd0);
    chk({tag, " done"}, 64'(done), 64'd0);
    chk({tag, " iter_count"}, 64'(iter_count), 64'd0);
    chk({tag, " escaped"}, 64'(escaped), 64'd0);
    chk({tag, " z_re_out"}, 64'(z_re_out), 64'd0);
    chk({tag, " z_im_out"}, 64'(z_im_out), 64'd0);
    chk({tag, " dp_z"}, {dp_rz, dp_iz}, 64'd0);
    chk({tag, " dp_c"}, {dp_rc, dp_ic}, 64'd0);
    chk({tag, " dp_aclr"}, 64'(dp_aclr), 64'd1);
  endtask

  // Called just after an edge; start is accepted at the next edge E.
  task automatic run_point(input string tag, input logic [31:0] zr0, input logic [31:0] zi0,
                           input logic [31:0] cr, input logic [31:0] ci,
                           input int n_exp, input logic esc_exp,
                           input logic [31:0] zr_exp, input logic [31:0] zi_exp,
                           input bit mid_start);
    int e, k, budget;
    bit busy_low;
    z0_re = zr0; z0_im = zi0; c_re = cr; c_im = ci;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    e = cyc;
    chk({tag, " busy after start"}, 64'(busy), 64'd1);
    chk({tag, " dp_c latched"}, {dp_rc, dp_ic}, {cr, ci});
    chk({tag, " dp_z latched"}, {dp_rz, dp_iz}, {zr0, zi0});
    k = 0; budget = n_exp * PIPE_LAT + 50; busy_low = 0;
    while (!done && k < budget) begin
      if (!busy) busy_low = 1;
      if (mid_start && k == 500) begin
        start = 1'b1; z0_re = 32'h3F800000; c_re = 32'h40000000;
      end
      if (k == 501) start = 1'b0;
      @(posedge clk); #1;
      k++;
    end
    chk({tag, " done seen"}, 64'(done), 64'd1);
    chk({tag, " done latency"}, 64'(cyc - e), 64'(n_exp * PIPE_LAT));
    chk({tag, " iter_count"}, 64'(iter_count), 64'(n_exp));
    chk({tag, " escaped"}, 64'(escaped), 64'(esc_exp));
    chk({tag, " z_out"}, {z_re_out, z_im_out}, {zr_exp, zi_exp});
    chk({tag, " busy in done"}, 64'(busy), 64'd1);
    chk({tag, " busy gap"}, 64'(busy_low), 64'd0);
    chk({tag, " dp_c held"}, {dp_rc, dp_ic}, {cr, ci});
    @(posedge clk); #1;
    chk({tag, " done pulse width"}, 64'(done), 64'd0);
    chk({tag, " idle busy"}, 64'(busy), 64'd0);
    chk({tag, " idle aclr"}, 64'(dp_aclr), 64'd1);
    chk({tag, " result held"}, {56'(iter_count), 7'd0, escaped}, {56'(n_exp), 7'd0, esc_exp});
  endtask

  initial begin
    bit saw_done;
    rst = 1'b1; start = 1'b1; dp_overflow = 1'b0;
    z0_re = 32'h3F800000; z0_im = 0; c_re = 32'h40000000; c_im = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("reset busy", 64'(busy), 64'd0);
    end
    chk_reset_vals("reset");
    rst = 1'b0; start = 1'b0;
    @(posedge clk); #1;

    run_point("c=2", 32'h0, 32'h0, 32'h40000000, 32'h0, 1, 1'b1, 32'h40000000, 32'h0, 0);
    run_point("c=1", 32'h0, 32'h0, 32'h3F800000, 32'h0, 2, 1'b1, 32'h40000000, 32'h0, 0);
    run_point("c=-1", 32'h0, 32'h0, 32'hBF800000, 32'h0, 255, 1'b0, 32'hBF800000, 32'h0, 1);

    dp_overflow = 1'b1;
    run_point("ovf", 32'h0, 32'h0, 32'h0, 32'h0, 1, 1'b1, 32'h0, 32'h0, 0);
    dp_overflow = 1'b0;

    // Reset mid-run: start at E, rst sampled at E+100.
    z0_re = 0; z0_im = 0; c_re = 32'hBF800000; c_im = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (99) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_reset_vals("midrst");
    saw_done = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || busy) saw_done = 1;
    end
    chk("midrst quiet", 64'(saw_done), 64'd0);
    run_point("after rst c=2", 32'h0, 32'h0, 32'h40000000, 32'h0, 1, 1'b1, 32'h40000000, 32'h0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
